hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 16-bit 5-stage CPU (IF, ID, EX, MEM, WB). It sits beside the opcode decoder and tracks in-flight register writes in a 3-entry scoreboard. From that it generates the load-use stall, the taken-branch kill and a drain/halt handshake that lets the UART loader freeze the core safely. It also keeps a saturating stall-cycle counter for debug readout.

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/hazard_ctrl_sat_counter.sv | 30 +++
 rtl/hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit 5-stage CPU: opcode encodings (same values
// as the opcode decoder), the hazard controller FSM state type, the scoreboard
// entry layout and the opcode class helpers used for hazard detection.
// -----------------------------------------------------------------------------
package cpu_pkg;

   // Opcode encodings, instr[15:12]
   localparam logic [3:0] LDA_imm    = 4'h0;
   localparam logic [3:0] STA_abs    = 4'h1;
   localparam logic [3:0] ADD_reg    = 4'h2;
   localparam logic [3:0] SUB_reg    = 4'h3;
   localparam logic [3:0] AND_reg    = 4'h4;
   localparam logic [3:0] OR_reg     = 4'h5;
   localparam logic [3:0] ADDI_imm   = 4'h6;
   localparam logic [3:0] SHL_reg    = 4'h7;
   localparam logic [3:0] MOV_reg    = 4'h8;
   localparam logic [3:0] OUT_reg    = 4'h9;
   localparam logic [3:0] BAF_regsub = 4'hA;
   localparam logic [3:0] JMP_abs    = 4'hB;
   localparam logic [3:0] CLI_op     = 4'hC;
   localparam logic [3:0] SEI_op     = 4'hD;
   localparam logic [3:0] HLT_op     = 4'hE;
   localparam logic [3:0] NONE       = 4'hF;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } hz_state_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] rd;
      logic       is_load;
   } sb_entry_t;

   // Reads rs: 1..10 (rs+rt ops and rs-only ops together)
   function automatic logic reads_rs(input logic [3:0] op);
      return (op >= STA_abs) && (op <= BAF_regsub);
   endfunction

   function automatic logic reads_rt(input logic [3:0] op);
      return ((op >= ADD_reg) && (op <= OR_reg)) || (op == BAF_regsub);
   endfunction

   function automatic logic writes_rd(input logic [3:0] op);
      return (op == LDA_imm) || ((op >= ADD_reg) && (op <= MOV_reg));
   endfunction

   function automatic logic is_load(input logic [3:0] op);
      return op == LDA_imm;
   endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear; clear beats increment.
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-high reset (count -> 0)
//   inc  in   count up by one unless already all-ones
//   clr  in   synchronous clear
//   cnt  out  current count
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencing controller. Tracks in-flight register writes in a
// 3-entry scoreboard (EX, MEM, WB), raises the load-use stall, the taken-branch
// kill, and runs the drain/halt handshake used by the UART loader.
//   i_clk, i_rst          clock / async active-high reset
//   i_id_valid            ID holds a real instruction
//   i_id_opcode/rd/rs/rt  ID instruction fields
//   i_br_taken            branch in EX resolved taken
//   i_halt_req            loader freeze request (level)
//   i_cnt_clr             clear stall counter
//   o_pc_en, o_ifid_en    PC / IF-ID load enables
//   o_ifid_flush          IF/ID loads a NOP
//   o_idex_bubble         ID/EX loads a NOP
//   o_halt_ack            pipeline empty and frozen (registered)
//   o_stall_cnt           saturating load-use stall cycle count
// -----------------------------------------------------------------------------
import cpu_pkg::*;

module hazard_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_id_valid,
   input  logic [3:0]       i_id_opcode,
   input  logic [3:0]       i_id_rd,
   input  logic [3:0]       i_id_rs,
   input  logic [3:0]       i_id_rt,
   input  logic             i_br_taken,
   input  logic             i_halt_req,
   input  logic             i_cnt_clr,
   output logic             o_pc_en,
   output logic             o_ifid_en,
   output logic             o_ifid_flush,
   output logic             o_idex_bubble,
   output logic             o_halt_ack,
   output logic [CNT_W-1:0] o_stall_cnt
);

   hz_state_t state;
   sb_entry_t sb_ex, sb_mem, sb_wb;
   sb_entry_t ex_next;
   logic      luse;
   logic      sb_empty;
   logic      cnt_inc;
   logic      halt_ack_q;

   // Only a load in EX can stall: ALU results are forwarded.
   always_comb begin
      luse = 1'b0;
      if (i_id_valid && sb_ex.valid && sb_ex.is_load) begin
         if (reads_rs(i_id_opcode) && (i_id_rs == sb_ex.rd)) luse = 1'b1;
         if (reads_rt(i_id_opcode) && (i_id_rt == sb_ex.rd)) luse = 1'b1;
      end
   end

   assign sb_empty = !(sb_ex.valid || sb_mem.valid || sb_wb.valid);

   always_comb begin
      o_pc_en       = 1'b1;
      o_ifid_en     = 1'b1;
      o_ifid_flush  = 1'b0;
      o_idex_bubble = 1'b0;
      cnt_inc       = 1'b0;
      unique case (state)
         RUN: begin
            // A taken branch kills the ID instruction, so any luse is moot.
            if (i_br_taken) begin
               o_ifid_flush  = 1'b1;
               o_idex_bubble = 1'b1;
            end else if (luse) begin
               o_pc_en       = 1'b0;
               o_ifid_en     = 1'b0;
               o_idex_bubble = 1'b1;
               cnt_inc       = 1'b1;
            end
         end
         DRAIN: begin
            o_pc_en       = i_br_taken;
            o_ifid_en     = 1'b0;
            o_ifid_flush  = i_br_taken;
            o_idex_bubble = 1'b1;
         end
         HALTED: begin
            o_pc_en       = 1'b0;
            o_ifid_en     = 1'b0;
            o_idex_bubble = 1'b1;
         end
         default: begin
            o_pc_en       = 1'b0;
            o_ifid_en     = 1'b0;
            o_idex_bubble = 1'b1;
         end
      endcase
   end

   always_comb begin
      ex_next.valid   = i_id_valid && !o_idex_bubble && writes_rd(i_id_opcode);
      ex_next.rd      = i_id_rd;
      ex_next.is_load = is_load(i_id_opcode);
   end

   // halt_ack_q is set on the same edge that enters HALTED, so it always
   // equals (state == HALTED) without a decode glitch.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= RUN;
         sb_ex      <= '0;
         sb_mem     <= '0;
         sb_wb      <= '0;
         halt_ack_q <= 1'b0;
      end else begin
         sb_wb  <= sb_mem;
         sb_mem <= sb_ex;
         sb_ex  <= ex_next;
         unique case (state)
            RUN: begin
               if (i_halt_req) state <= DRAIN;
            end
            DRAIN: begin
               if (!i_halt_req) begin
                  state <= RUN;
               end else if (sb_empty) begin
                  state      <= HALTED;
                  halt_ack_q <= 1'b1;
               end
            end
            HALTED: begin
               if (!i_halt_req) begin
                  state      <= RUN;
                  halt_ack_q <= 1'b0;
               end
            end
            default: begin
               state      <= RUN;
               halt_ack_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_halt_ack = halt_ack_q;

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk (i_clk),
      .rst (i_rst),
      .inc (cnt_inc),
      .clr (i_cnt_clr),
      .cnt (o_stall_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed scenarios plus randomized traffic for hazard_ctrl (CNT_W = 4),
// checked every cycle against a behavioural model of the pipeline controller.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_id_valid = 1'b0;
   logic [3:0]    i_id_opcode = '0;
   logic [3:0]    i_id_rd = '0;
   logic [3:0]    i_id_rs = '0;
   logic [3:0]    i_id_rt = '0;
   logic          i_br_taken = 1'b0;
   logic          i_halt_req = 1'b0;
   logic          i_cnt_clr = 1'b0;
   logic          o_pc_en, o_ifid_en, o_ifid_flush, o_idex_bubble, o_halt_ack;
   logic [CW-1:0] o_stall_cnt;

   hazard_ctrl #(.CNT_W(CW)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_id_valid    (i_id_valid),
      .i_id_opcode   (i_id_opcode),
      .i_id_rd       (i_id_rd),
      .i_id_rs       (i_id_rs),
      .i_id_rt       (i_id_rt),
      .i_br_taken    (i_br_taken),
      .i_halt_req    (i_halt_req),
      .i_cnt_clr     (i_cnt_clr),
      .o_pc_en       (o_pc_en),
      .o_ifid_en     (o_ifid_en),
      .o_ifid_flush  (o_ifid_flush),
      .o_idex_bubble (o_idex_bubble),
      .o_halt_ack    (o_halt_ack),
      .o_stall_cnt   (o_stall_cnt)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // in-flight writers, index 0 = instruction now in EX
   typedef struct {
      bit       v;
      bit [3:0] rd;
      bit       ld;
   } inflight_t;

   inflight_t pipe_m[3];
   int        mode_m;      // 0 running, 1 draining, 2 halted
   int        cnt_m;
   bit        e_pc, e_ifid, e_flush, e_bub;

   function automatic bit m_reads_rs(input bit [3:0] op);
      return op inside {[4'd1:4'd10]};
   endfunction
   function automatic bit m_reads_rt(input bit [3:0] op);
      return op inside {[4'd2:4'd5], 4'd10};
   endfunction
   function automatic bit m_writes(input bit [3:0] op);
      return op inside {4'd0, [4'd2:4'd8]};
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) pipe_m[i] = '{0, 4'd0, 0};
      mode_m = 0;
      cnt_m  = 0;
   endfunction

   // One clock cycle: drive ID/control inputs, check all outputs against the
   // model, advance through the rising edge and update the model.
   task automatic step(input bit v, input bit [3:0] op, input bit [3:0] rd,
                       input bit [3:0] rs, input bit [3:0] rt,
                       input bit br, input bit halt, input bit clr);
      bit lu, issue, empty;
      i_id_valid  = v;
      i_id_opcode = op;
      i_id_rd     = rd;
      i_id_rs     = rs;
      i_id_rt     = rt;
      i_br_taken  = br;
      i_halt_req  = halt;
      i_cnt_clr   = clr;
      #1;
      lu = v && pipe_m[0].v && pipe_m[0].ld &&
           ((m_reads_rs(op) && rs == pipe_m[0].rd) || (m_reads_rt(op) && rt == pipe_m[0].rd));
      if (mode_m == 0) begin
         if (br)      {e_pc, e_ifid, e_flush, e_bub} = 4'b1111;
         else if (lu) {e_pc, e_ifid, e_flush, e_bub} = 4'b0001;
         else         {e_pc, e_ifid, e_flush, e_bub} = 4'b1100;
      end else if (mode_m == 1) begin
         e_pc = br; e_ifid = 0; e_flush = br; e_bub = 1;
      end else begin
         {e_pc, e_ifid, e_flush, e_bub} = 4'b0001;
      end
      chk("pc_en", o_pc_en, e_pc);
      if (!(mode_m == 1 && br)) chk("ifid_en", o_ifid_en, e_ifid);
      chk("ifid_flush", o_ifid_flush, e_flush);
      chk("idex_bubble", o_idex_bubble, e_bub);
      chk("halt_ack", o_halt_ack, mode_m == 2);
      chk("stall_cnt", o_stall_cnt, cnt_m);
      @(posedge i_clk);
      issue = v && !e_bub && m_writes(op);
      empty = !(pipe_m[0].v || pipe_m[1].v || pipe_m[2].v);
      pipe_m[2] = pipe_m[1];
      pipe_m[1] = pipe_m[0];
      pipe_m[0] = '{issue, rd, op == 4'd0};
      if (clr) cnt_m = 0;
      else if (mode_m == 0 && !br && lu && cnt_m < CMAX) cnt_m++;
      case (mode_m)
         0: if (halt) mode_m = 1;
         1: if (!halt) mode_m = 0; else if (empty) mode_m = 2;
         default: if (!halt) mode_m = 0;
      endcase
      #1;
   endtask

   // Asynchronous reset pulse taken between clock edges; outputs must drop to
   // reset values without waiting for an edge.
   task automatic do_reset();
      i_rst = 1'b1;
      i_id_valid = 0; i_br_taken = 0; i_halt_req = 0; i_cnt_clr = 0;
      #1;
      model_reset();
      chk("rst_ack", o_halt_ack, 0);
      chk("rst_cnt", o_stall_cnt, 0);
      chk("rst_pc_en", o_pc_en, 1);
      chk("rst_ifid_en", o_ifid_en, 1);
      chk("rst_flush", o_ifid_flush, 0);
      chk("rst_bubble", o_idex_bubble, 0);
      @(negedge i_clk);
      i_rst = 1'b0;
      @(posedge i_clk);
      #1;
   endtask

   bit       hold, flush_prev, halt_r;
   bit [3:0] r_op, r_rd, r_rs, r_rt;
   bit       r_v;
   int       k_hit;

   initial begin
      model_reset();
      #2;
      do_reset();

      // load-use: LDA R3 then ADD rs=3 rt=2 -> one stall, then issues
      step(1, 4'h0, 4'd3, 4'd0, 4'd0, 0, 0, 0);
      step(1, 4'h2, 4'd6, 4'd3, 4'd2, 0, 0, 0);
      chk("lu_cnt", o_stall_cnt, 1);
      step(1, 4'h2, 4'd6, 4'd3, 4'd2, 0, 0, 0);
      chk("lu_one_cycle", o_stall_cnt, 1);

      // no false stalls
      step(1, 4'h0, 4'd3, 4'd0, 4'd0, 0, 0, 0);
      step(1, 4'h2, 4'd7, 4'd4, 4'd5, 0, 0, 0);
      step(1, 4'h2, 4'd3, 4'd1, 4'd1, 0, 0, 0);
      step(1, 4'h3, 4'd8, 4'd3, 4'd3, 0, 0, 0);
      chk("nofalse_cnt", o_stall_cnt, 1);

      // taken branch over a load-use consumer
      step(1, 4'h0, 4'd3, 4'd0, 4'd0, 0, 0, 0);
      step(1, 4'h2, 4'd6, 4'd3, 4'd2, 1, 0, 0);
      chk("br_cnt", o_stall_cnt, 1);

      // halt handshake from a full scoreboard
      do_reset();
      step(1, 4'h2, 4'd1, 4'd0, 4'd0, 0, 0, 0);
      step(1, 4'h2, 4'd2, 4'd0, 4'd0, 0, 0, 0);
      step(1, 4'h2, 4'd3, 4'd0, 4'd0, 0, 1, 0);
      k_hit = 0;
      for (int k = 1; k <= 10; k++) begin
         step(1, 4'h3, 4'd7, 4'd1, 4'd2, 0, 1, 0);
         if (o_halt_ack) begin
            k_hit = k;
            break;
         end
      end
      chk("ack_edge", k_hit, 4);
      step(1, 4'h3, 4'd7, 4'd1, 4'd2, 0, 0, 0);
      chk("release_ack", o_halt_ack, 0);
      step(1, 4'h3, 4'd7, 4'd1, 4'd2, 0, 0, 0);

      // reset mid-drain with a load sitting in EX
      step(1, 4'h0, 4'd5, 4'd0, 4'd0, 0, 1, 0);
      step(0, 4'h0, 4'd0, 4'd0, 4'd0, 0, 1, 0);
      do_reset();
      step(1, 4'h2, 4'd6, 4'd5, 4'd5, 0, 0, 0);

      // drain abandoned before completion
      step(1, 4'h2, 4'd1, 4'd0, 4'd0, 0, 1, 0);
      step(1, 4'h2, 4'd9, 4'd1, 4'd1, 0, 0, 0);
      step(1, 4'h2, 4'd9, 4'd1, 4'd1, 0, 0, 0);

      // saturation at 15, then clear beats a stall increment
      do_reset();
      for (int p = 0; p < 20; p++) begin
         step(1, 4'h0, 4'd3, 4'd0, 4'd0, 0, 0, 0);
         step(1, 4'h2, 4'd6, 4'd2, 4'd3, 0, 0, 0);
         step(1, 4'h2, 4'd6, 4'd2, 4'd3, 0, 0, 0);
      end
      chk("sat_cnt", o_stall_cnt, CMAX);
      step(1, 4'h0, 4'd3, 4'd0, 4'd0, 0, 0, 0);
      step(1, 4'h2, 4'd6, 4'd3, 4'd2, 0, 0, 1);
      chk("clr_wins", o_stall_cnt, 0);

      // randomized traffic; stalled ID instructions are held, flushed ones die
      do_reset();
      hold = 0; flush_prev = 0; halt_r = 0;
      r_v = 0; r_op = 0; r_rd = 0; r_rs = 0; r_rt = 0;
      for (int n = 0; n < 800; n++) begin
         if (!hold) begin
            r_v  = ($urandom_range(0, 3) != 0) && !flush_prev;
            r_op = 4'($urandom_range(0, 15));
            r_rd = 4'($urandom_range(0, 3));
            r_rs = 4'($urandom_range(0, 3));
            r_rt = 4'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 29) == 0) halt_r = !halt_r;
         step(r_v, r_op, r_rd, r_rs, r_rt,
              $urandom_range(0, 7) == 0, halt_r, $urandom_range(0, 31) == 0);
         hold       = !e_ifid && !e_flush;
         flush_prev = e_flush;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
